core_pipe_fetch_realign: RTL

- Sits between instruction fetch and decode.
- Accepts 32-bit naturally aligned fetch words and realigns the mixed 16/32-bit RVC instruction stream into exactly one complete instruction per decode handshake, tagged with its PC, size and fetch error.
- The decode-stage immediate/field decode consumes its output directly. It sequences the decoder's input and absorbs fetch/decode rate mismatch with a small halfword buffer.

---
 rtl/core_pipe_fetch_realign.sv | 130 +++++++++++++
 1 files changed

// File: rtl/core_pipe_fetch_realign.sv
// rtl/core_pipe_fetch_realign.sv - realigns 32-bit fetch words into one RVC/RV32 instruction per decode handshake
//
// Ports:
//   g_clk, g_resetn           clock, asynchronous active-low reset
//   s_flush, s_flush_pc       redirect: drop buffered halfwords, restart at s_flush_pc
//   f_valid/f_ready/f_data/f_error
//                             fetch word handshake (f_data[15:0] is the lower address)
//   d_valid/d_ready           decode handshake
//   d_instr/d_pc/d_size/d_error
//                             head instruction, its PC, 1 = 32-bit, fetch error flag
`timescale 1ns/1ps

module core_pipe_fetch_realign #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] PC_RESET = 'h80000000
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            s_flush,
  input  logic [PC_W-1:0] s_flush_pc,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [31:0]     f_data,
  input  logic            f_error,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [31:0]     d_instr,
  output logic [PC_W-1:0] d_pc,
  output logic            d_size,
  output logic            d_error
);

  // hw[0] is the oldest halfword; entries at index >= count are kept at zero
  logic [15:0]     hw [4];
  logic [3:0]      err;
  logic [2:0]      count;
  logic [PC_W-1:0] pc;
  logic            drop_first;
  logic            halted;

  logic [15:0]     nhw [4];
  logic [3:0]      nerr;
  logic [2:0]      count_next;
  logic [2:0]      pop_n;
  logic [2:0]      push_n;
  logic [2:0]      base;
  logic            need2;
  logic            head_ok;
  logic            pop;
  logic            push;

  assign need2   = (hw[0][1:0] == 2'b11);
  assign head_ok = need2 ? (count >= 3'd2) : (count >= 3'd1);

  // An errored head is released even if incomplete so decode can trap on it
  assign d_valid = !halted && (head_ok || ((count != 3'd0) && err[0]));
  assign f_ready = !halted && (count <= 3'd2);

  assign d_size  = need2;
  assign d_instr = need2 ? {((count >= 3'd2) ? hw[1] : 16'h0), hw[0]} : {16'h0, hw[0]};
  assign d_error = err[0] | (need2 && (count >= 3'd2) && err[1]);
  assign d_pc    = pc;

  assign pop  = d_valid && d_ready;
  assign push = f_valid && f_ready;

  // On the error path a 32-bit head may leave with only one halfword present
  assign pop_n  = !pop ? 3'd0 : ((need2 && (count >= 3'd2)) ? 3'd2 : 3'd1);
  assign push_n = !push ? 3'd0 : (drop_first ? 3'd1 : 3'd2);
  assign base   = count - pop_n;
  assign count_next = count - pop_n + push_n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nhw[i]  = 16'h0;
      nerr[i] = 1'b0;
    end
    // Shift surviving entries toward hw[0]
    for (int i = 0; i < 4; i++) begin
      int j;
      j = i + int'(pop_n);
      if (j < int'(count)) begin
        nhw[i]  = hw[j[1:0]];
        nerr[i] = err[j[1:0]];
      end
    end
    // Append after the survivors; f_ready guarantees base <= 2
    if (push) begin
      if (drop_first) begin
        nhw[base[1:0]]  = f_data[31:16];
        nerr[base[1:0]] = f_error;
      end else begin
        nhw[base[1:0]]          = f_data[15:0];
        nerr[base[1:0]]         = f_error;
        nhw[base[1:0] + 2'd1]   = f_data[31:16];
        nerr[base[1:0] + 2'd1]  = f_error;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      hw         <= '{default: 16'h0};
      err        <= 4'h0;
      count      <= 3'd0;
      pc         <= PC_RESET;
      drop_first <= PC_RESET[1];
      halted     <= 1'b0;
    end else if (s_flush) begin
      hw         <= '{default: 16'h0};
      err        <= 4'h0;
      count      <= 3'd0;
      pc         <= {s_flush_pc[PC_W-1:1], 1'b0};
      drop_first <= s_flush_pc[1];
      halted     <= 1'b0;
    end else begin
      hw    <= nhw;
      err   <= nerr;
      count <= count_next;
      pc    <= pc + PC_W'({pop_n, 1'b0});
      if (push) begin
        drop_first <= 1'b0;
      end
      if (pop && d_error) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
